instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Fetch/execute sequencer for the OLED display core. Owns the program counter,
//  reads 21-bit words from the synchronous instruction ROM, and presents each word
//  for one cycle to the instruction decoder and ALU. It resolves branches and stalls
//  on I2C transfers until the I2C controller reports completion.
// PARAMETERS
//  PC_W         8     program counter / ROM address width
//  I2C_TIMEOUT  1023  max cycles in I2C_WAIT before a fault; 0 disables the timeout
// PORTS
//  i_clk          in   1     clock, rising edge
//  i_rst_n        in   1     asynchronous active-low reset
//  i_start        in   1     level; leave IDLE and run from i_start_pc
//  i_start_pc     in   PC_W  entry address, sampled in the cycle i_start is taken
//  i_stop         in   1     synchronous abort to IDLE
//  o_rom_en       out  1     ROM read enable
//  o_rom_addr     out  PC_W  ROM read address
//  i_rom_data     in   21    ROM word, valid 1 cycle after o_rom_en
//  o_instr        out  21    instruction register, drives decoder i_instr
//  o_instr_valid  out  1     1-cycle execute strobe; qualifies decoder write enables
//  i_alu_zero     in   1     ALU zero flag for the current o_instr (combinational)
//  o_i2c_start    out  1     1-cycle start pulse to the I2C controller
//  i_i2c_done     in   1     1-cycle transfer-complete pulse
//  o_pc           out  PC_W  address of the instruction in o_instr
//  o_busy         out  1     high in every state except IDLE and HALT
//  o_halted       out  1     high in HALT
//  o_err          out  1     sticky I2C timeout flag; cleared by i_start or reset
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE; pc=0; o_instr=0; o_err=0; all other outputs 0.
//  Opcode = o_instr[20:16]:
//   BEQ  5'b10011, BEQF 5'b10101: taken if i_alu_zero=1; target = o_instr[7:0], zero-extended or truncated to PC_W.
//   JMP  5'b11000: unconditional jump to o_instr[7:0].
//   I2C  5'b11010: start an I2C transfer.
//   HALT 5'b11111: stop. All other opcodes: pc+1.
//  States:
//   IDLE:     i_start=1 -> pc<=i_start_pc, o_err<=0, go to FETCH.
//   FETCH:    o_rom_en=1 and o_rom_addr=pc for 1 cycle; go to LOAD.
//   LOAD:     o_instr<=i_rom_data; go to EXEC.
//   EXEC:     o_instr_valid=1 for exactly 1 cycle. Next pc and state by opcode:
//               branch/JMP taken -> pc<=target, FETCH
//               I2C              -> o_i2c_start=1, pc<=pc+1, I2C_WAIT, timeout counter cleared
//               HALT             -> HALT, pc unchanged
//               else             -> pc<=pc+1, FETCH
//   I2C_WAIT: i_i2c_done=1 -> FETCH. Timeout counter counts up each cycle;
//             reaching I2C_TIMEOUT -> o_err<=1, HALT.
//   HALT:     held until i_start (same action as from IDLE) or reset.
//  Throughput: 3 cycles per non-I2C instruction (FETCH, LOAD, EXEC).
//  pc+1 wraps from 2^PC_W-1 to 0 with no error.
//  i_i2c_done is ignored outside I2C_WAIT, including a pulse coincident with o_i2c_start.
//  i_stop=1 in any state -> IDLE next cycle, with priority over every other transition.
//   o_instr_valid and o_i2c_start are suppressed in that cycle.
//   pc and o_instr are held; o_err is unaffected.
//  i_start in any state other than IDLE or HALT is ignored.
//  o_i2c_start never re-asserts until a new EXEC of an I2C opcode.
//  Async reset mid-transfer returns to IDLE immediately; no pending done is remembered.
// TESTING
//  T1: ROM[0..2]=ADD,SUB,HALT; i_start, i_start_pc=0 -> o_instr_valid at cycles 3,6,9
//      with o_pc=0,1,2; o_halted=1 from cycle 10; o_busy=0 there.
//  T2: ROM[4]=BEQ imm=8'h20: i_alu_zero=1 -> next o_rom_addr=8'h20;
//      repeat with i_alu_zero=0 -> next o_rom_addr=8'h05.
//  T3: ROM[0]=I2C: one o_i2c_start pulse; i_i2c_done held off 50 cycles -> no FETCH;
//      done pulse -> FETCH of addr 1 on the next cycle.
//  T4: I2C_TIMEOUT=16, i_i2c_done never pulsed -> o_err=1 and o_halted=1 after
//      16 I2C_WAIT cycles; i_start clears o_err.
//  T5: PC_W=4, ROM[15]=ADD -> next o_rom_addr=0.
//      Separately, i_stop asserted during I2C_WAIT -> IDLE, o_busy=0, no further o_i2c_start.
//  T6: i_rst_n pulsed low mid-I2C_WAIT -> all outputs 0 asynchronously;
//      a later i_i2c_done pulse has no effect.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the OLED core: walks the PC through the instruction ROM at
// 3 cycles per instruction, resolves branches, and parks in I2C_WAIT until done or timeout.
module instr_sequencer #(
  parameter int PC_W        = 8,
  parameter int I2C_TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [PC_W-1:0] i_start_pc,
  input  logic            i_stop,
  output logic            o_rom_en,
  output logic [PC_W-1:0] o_rom_addr,
  input  logic [20:0]     i_rom_data,
  output logic [20:0]     o_instr,
  output logic            o_instr_valid,
  input  logic            i_alu_zero,
  output logic            o_i2c_start,
  input  logic            i_i2c_done,
  output logic [PC_W-1:0] o_pc,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_err
);

  localparam int TW = (I2C_TIMEOUT > 1) ? $clog2(I2C_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((I2C_TIMEOUT > 0) ? I2C_TIMEOUT - 1 : 0);

  localparam logic [4:0] OP_BEQ  = 5'b10011;
  localparam logic [4:0] OP_BEQF = 5'b10101;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_I2C  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_WAIT, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [20:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic [4:0]        opcode;
  logic [PC_W-1:0]   br_tgt;
  logic [PC_W-1:0]   pc_inc;

  assign opcode = instr_q[20:16];
  // The 8-bit immediate is zero-extended or truncated to the PC width.
  assign br_tgt = PC_W'(instr_q[7:0]);
  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    // Stop overrides everything and freezes pc, instruction and error flag.
    if (i_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            state_d = S_FETCH;
            pc_d    = i_start_pc;
            err_d   = 1'b0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          instr_d = i_rom_data;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
          case (opcode)
            OP_BEQ, OP_BEQF: if (i_alu_zero) pc_d = br_tgt;
            OP_JMP:          pc_d = br_tgt;
            OP_I2C: begin
              state_d = S_WAIT;
              tmo_d   = '0;
            end
            OP_HALT: begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          if (i_i2c_done) begin
            state_d = S_FETCH;
          end else if (I2C_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rom_en      = 1'b0;
    o_instr_valid = 1'b0;
    o_i2c_start   = 1'b0;
    case (state_q)
      S_FETCH: o_rom_en = 1'b1;
      S_EXEC: begin
        o_instr_valid = !i_stop;
        o_i2c_start   = !i_stop && (opcode == OP_I2C);
      end
      default: ;
    endcase
  end

  assign o_rom_addr = pc_q;
  assign o_pc       = pc_q;
  assign o_instr    = instr_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign o_halted   = (state_q == S_HALT);

endmodule
